// File: rtl/prog_ctr_ras.sv
// Instruction-fetch program counter with Start-selected program table,
// run/halt control and a hardware return-address stack for Call/Ret.
module prog_ctr_ras #(
    parameter int A           = 10,
    parameter int NPROG       = 3,
    parameter int PROG_STRIDE = 100,
    parameter int RAS_DEPTH   = 4,
    parameter int REL_W       = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BranchAbsEn,
    input  logic             BranchRelEn,
    input  logic             Cond,
    input  logic             Call,
    input  logic             Ret,
    input  logic [A-1:0]     AbsTarget,
    input  logic [REL_W-1:0] RelOffset,
    output logic [A-1:0]     ProgCtr,
    output logic [2:0]       ProgIdx,
    output logic             Running,
    output logic             Done,
    output logic             StackErr
);

    localparam int PW = $clog2(RAS_DEPTH + 1);
    localparam int IW = $clog2(RAS_DEPTH);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RUN    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [A-1:0]    pc_q, pc_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_r_q;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            err_q, err_d;
    logic            running_q, running_d;
    logic            done_q, done_d;

    logic [A-1:0]    ras_q [RAS_DEPTH];
    logic            ras_we;
    logic [IW-1:0]   ras_widx;
    logic [A-1:0]    ras_wdata;

    logic            rise, fall;
    logic            ras_empty, ras_full;
    logic [A-1:0]    pc_inc, pc_load, rel_ext, ras_top;
    logic [CW-1:0]   cnt_inc;

    assign rise      = Start & ~start_r_q;
    assign fall      = ~Start & start_r_q;
    assign ras_empty = (ptr_q == '0);
    assign ras_full  = (ptr_q == PW'(RAS_DEPTH));
    assign pc_inc    = pc_q + A'(1);
    assign rel_ext   = A'(32'(signed'(RelOffset)));
    assign pc_load   = A'((32'(cnt_q) - 32'd1) * 32'(PROG_STRIDE));
    assign ras_top   = ras_q[IW'(ptr_q - PW'(1))];
    // Program selector cycles 1..NPROG; the loaded program is cnt-1.
    assign cnt_inc   = (cnt_q == CW'(NPROG)) ? CW'(1) : cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        ras_we    = 1'b0;
        ras_widx  = IW'(ptr_q);
        ras_wdata = pc_inc;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (rise) begin
                    cnt_d   = cnt_inc;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (fall) begin
                    idx_d   = 3'(cnt_q - CW'(1));
                    pc_d    = pc_load;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A new Start request aborts the running program before any decode rule.
                if (rise) begin
                    cnt_d   = cnt_inc;
                    state_d = S_ARMED;
                end else if (Halt) begin
                    state_d = S_HALTED;
                end else if (Ret) begin
                    if (ras_empty) begin
                        err_d = 1'b1;
                        pc_d  = pc_inc;
                    end else begin
                        pc_d  = ras_top;
                        ptr_d = ptr_q - PW'(1);
                    end
                end else if (Call) begin
                    pc_d = AbsTarget;
                    if (ras_full) begin
                        err_d = 1'b1;
                    end else begin
                        ras_we = 1'b1;
                        ptr_d  = ptr_q + PW'(1);
                    end
                end else if (BranchAbsEn && Cond) begin
                    pc_d = AbsTarget;
                end else if (BranchRelEn && Cond) begin
                    pc_d = pc_q + rel_ext;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_HALTED);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            start_r_q <= 1'b0;
            ptr_q     <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            start_r_q <= Start;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Stack entries are storage only; validity is tracked by ptr_q alone.
    always_ff @(posedge Clk) begin
        if (ras_we && !Reset) begin
            ras_q[ras_widx] <= ras_wdata;
        end
    end

    assign ProgCtr  = pc_q;
    assign ProgIdx  = idx_q;
    assign Running  = running_q;
    assign Done     = done_q;
    assign StackErr = err_q;

endmodule

// File: tb/tb_prog_ctr_ras.sv
// Bench for prog_ctr_ras: directed scenarios then random control traffic,
// every cycle compared against a queue-based behavioural model.
module tb_prog_ctr_ras;

    localparam int A           = 10;
    localparam int NPROG       = 3;
    localparam int PROG_STRIDE = 100;
    localparam int RAS_DEPTH   = 4;
    localparam int REL_W       = 8;
    localparam int MODV        = 1 << A;

    logic             Clk = 1'b0;
    logic             Reset, Start, Halt, BranchAbsEn, BranchRelEn, Cond, Call, Ret;
    logic [A-1:0]     AbsTarget;
    logic [REL_W-1:0] RelOffset;
    logic [A-1:0]     ProgCtr;
    logic [2:0]       ProgIdx;
    logic             Running, Done, StackErr;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 idle, 1 armed, 2 run, 3 halted
    int m_state, m_pc, m_idx, m_cnt, m_start_r, m_err;
    int m_ras[$];

    prog_ctr_ras #(
        .A(A), .NPROG(NPROG), .PROG_STRIDE(PROG_STRIDE),
        .RAS_DEPTH(RAS_DEPTH), .REL_W(REL_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn), .Cond(Cond),
        .Call(Call), .Ret(Ret), .AbsTarget(AbsTarget), .RelOffset(RelOffset),
        .ProgCtr(ProgCtr), .ProgIdx(ProgIdx), .Running(Running), .Done(Done),
        .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_cnt(input int c);
        return (c == NPROG) ? 1 : c + 1;
    endfunction

    task automatic model_step();
        bit rise, fall;
        int off;
        rise = Start && !m_start_r;
        fall = !Start && m_start_r;
        if (Reset) begin
            m_state = 0; m_pc = 0; m_idx = 0; m_cnt = 0; m_start_r = 0; m_err = 0;
            m_ras.delete();
            return;
        end
        case (m_state)
            0, 3: if (rise) begin m_cnt = next_cnt(m_cnt); m_state = 1; end
            1: if (fall) begin
                m_idx = m_cnt - 1;
                m_pc  = ((m_cnt - 1) * PROG_STRIDE) % MODV;
                m_ras.delete();
                m_err = 0;
                m_state = 2;
            end
            default: begin
                if (rise) begin
                    m_cnt = next_cnt(m_cnt); m_state = 1;
                end else if (Halt) begin
                    m_state = 3;
                end else if (Ret) begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin m_err = 1; m_pc = (m_pc + 1) % MODV; end
                end else if (Call) begin
                    if (m_ras.size() < RAS_DEPTH) m_ras.push_back((m_pc + 1) % MODV);
                    else m_err = 1;
                    m_pc = int'(AbsTarget);
                end else if (BranchAbsEn && Cond) begin
                    m_pc = int'(AbsTarget);
                end else if (BranchRelEn && Cond) begin
                    off  = int'(RelOffset);
                    if (off >= (1 << (REL_W - 1))) off -= (1 << REL_W);
                    m_pc = (((m_pc + off) % MODV) + MODV) % MODV;
                end else begin
                    m_pc = (m_pc + 1) % MODV;
                end
            end
        endcase
        m_start_r = Start;
    endtask

    // One clock: model consumes the same inputs the DUT samples, then compare.
    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
        check("pc", 32'(ProgCtr), 32'(m_pc));
        check("idx", 32'(ProgIdx), 32'(m_idx));
        check("running", 32'(Running), 32'(m_state == 2));
        check("done", 32'(Done), 32'(m_state == 3));
        check("stackerr", 32'(StackErr), 32'(m_err));
    endtask

    task automatic clear_ctl();
        Halt = 0; BranchAbsEn = 0; BranchRelEn = 0; Cond = 0; Call = 0; Ret = 0;
        AbsTarget = '0; RelOffset = '0;
    endtask

    task automatic pulse_start();
        clear_ctl();
        Start = 1; cycle();
        cycle();
        Start = 0; cycle();
    endtask

    task automatic jump_abs(input int tgt);
        clear_ctl(); BranchAbsEn = 1; Cond = 1; AbsTarget = A'(tgt); cycle(); clear_ctl();
    endtask

    task automatic do_call(input int tgt);
        clear_ctl(); Call = 1; AbsTarget = A'(tgt); cycle(); clear_ctl();
    endtask

    task automatic do_ret();
        clear_ctl(); Ret = 1; cycle(); clear_ctl();
    endtask

    initial begin
        Reset = 1; Start = 0; clear_ctl();
        cycle(); cycle();
        check("reset_pc", 32'(ProgCtr), 0);
        check("reset_running", 32'(Running), 0);
        Reset = 0;

        // Program 0 load and sequential counting
        Start = 1; cycle(); cycle();
        check("armed_pc_hold", 32'(ProgCtr), 0);
        Start = 0; cycle();
        check("tp1_running", 32'(Running), 1);
        check("tp1_idx", 32'(ProgIdx), 0);
        for (int i = 0; i < 5; i++) cycle();
        check("tp1_pc5", 32'(ProgCtr), 5);

        // Relative / absolute branches
        BranchRelEn = 1; RelOffset = 8'hFD; Cond = 1; cycle();
        check("tp2_rel_taken", 32'(ProgCtr), 2);
        Cond = 0; cycle();
        check("tp2_rel_not_taken", 32'(ProgCtr), 3);
        jump_abs(40);
        check("tp2_abs", 32'(ProgCtr), 40);

        // Nested call/return and underflow
        jump_abs(10);
        do_call(50);  check("tp3_call1", 32'(ProgCtr), 50);
        cycle();
        do_call(70);  check("tp3_call2", 32'(ProgCtr), 70);
        do_ret();     check("tp3_ret1", 32'(ProgCtr), 52);
        do_ret();     check("tp3_ret2", 32'(ProgCtr), 11);
        do_ret();     check("tp3_underflow_pc", 32'(ProgCtr), 12);
        check("tp3_underflow_err", 32'(StackErr), 1);

        // Overflow: reload (clears StackErr), then RAS_DEPTH+1 calls
        pulse_start();
        check("tp4_reload_err", 32'(StackErr), 0);
        check("tp4_reload_pc", 32'(ProgCtr), 100);
        for (int i = 0; i <= RAS_DEPTH; i++) do_call(300 + i);
        check("tp4_ovf_pc", 32'(ProgCtr), 300 + RAS_DEPTH);
        check("tp4_ovf_err", 32'(StackErr), 1);
        for (int i = 0; i < RAS_DEPTH; i++) do_ret();
        check("tp4_lifo_last", 32'(ProgCtr), 101);

        // Halt, then program table walk with wrap
        Reset = 1; cycle(); Reset = 0;
        pulse_start();
        jump_abs(20);
        Halt = 1; cycle(); clear_ctl();
        check("tp5_done", 32'(Done), 1);
        check("tp5_running", 32'(Running), 0);
        for (int i = 0; i < 10; i++) cycle();
        check("tp5_hold", 32'(ProgCtr), 20);
        pulse_start();
        check("tp5_prog1_pc", 32'(ProgCtr), 100);
        check("tp5_prog1_idx", 32'(ProgIdx), 1);
        pulse_start();
        check("tp5_prog2_pc", 32'(ProgCtr), 200);
        pulse_start();
        check("tp5_wrap_pc", 32'(ProgCtr), 0);
        check("tp5_wrap_idx", 32'(ProgIdx), 0);

        // Halt beats Ret; Reset beats Call
        do_call(60);
        clear_ctl(); Halt = 1; Ret = 1; cycle(); clear_ctl();
        check("tp6_halt_wins_done", 32'(Done), 1);
        check("tp6_halt_wins_pc", 32'(ProgCtr), 60);
        pulse_start();
        do_ret();
        check("tp6_err_before_reset", 32'(StackErr), 1);
        Reset = 1; Call = 1; AbsTarget = A'(77); cycle(); Reset = 0; clear_ctl();
        check("tp6_reset_pc", 32'(ProgCtr), 0);
        check("tp6_reset_err", 32'(StackErr), 0);
        check("tp6_reset_running", 32'(Running), 0);
        BranchAbsEn = 1; Cond = 1; AbsTarget = A'(40);
        for (int i = 0; i < 5; i++) cycle();
        check("tp6_idle_hold", 32'(ProgCtr), 0);
        clear_ctl();

        // Random control traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) Start = ~Start;
            Reset       = ($urandom_range(0, 599) == 0);
            Halt        = ($urandom_range(0, 39) == 0);
            Ret         = ($urandom_range(0, 5) == 0);
            Call        = ($urandom_range(0, 5) == 0);
            BranchAbsEn = ($urandom_range(0, 5) == 0);
            BranchRelEn = ($urandom_range(0, 4) == 0);
            Cond        = 1'($urandom_range(0, 1));
            AbsTarget   = A'($urandom_range(0, MODV - 1));
            RelOffset   = REL_W'($urandom_range(0, (1 << REL_W) - 1));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
